// File: rtl/sm3_ahb_pkg.sv
// Shared AHB encodings, fetch FSM states and block geometry for the SM3 message fetcher.
package sm3_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;
    localparam int         BLOCK_WORDS   = 16;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        BURST,
        HOLD,
        FIN
    } fetch_state_t;

    // 64-byte block base; the 14-bit index sum lets the carry reach address bit 19.
    function automatic logic [19:0] blk_base(input logic [12:0] sar, input logic [12:0] blk);
        logic [13:0] idx;
        idx = {1'b0, sar} + {1'b0, blk};
        return {idx, 6'b00_0000};
    endfunction

endpackage

// File: rtl/sm3_blk_buf.sv
// 16x32 assembly register for one message block, word 0 in the top bits; writes land 1 cycle later.
// No backpressure: the caller gates wr_en, and clr wipes a partially assembled block.
module sm3_blk_buf
    import sm3_ahb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [3:0]   wr_idx,
    input  logic [31:0]  wr_dat,
    output logic [511:0] blk
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk <= '0;
        end else if (clr) begin
            blk <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < BLOCK_WORDS; k++) begin
                if (wr_idx == 4'(k)) begin
                    blk[511 - 32*k -: 32] <= wr_dat;
                end
            end
        end
    end

endmodule

// File: rtl/sm3_ahb_fetch.sv
// AHB INCR16 master fetching BSR 64-byte blocks into MSG_BLOCK; first NONSEQ one cycle after START.
// Stalls on HREADY=0; holds each block with BLK_VALID until BLK_READY before the next burst.
module sm3_ahb_fetch
    import sm3_ahb_pkg::*;
#(
    parameter int HADDR_W = 32
) (
    input  logic               AHB_HCLK,
    input  logic               AHB_HRESET,
    input  logic               START,
    input  logic [12:0]        SAR_ADDR,
    input  logic [12:0]        BSR,
    output logic [HADDR_W-1:0] AHB_HADDR,
    output logic [1:0]         AHB_HTRANS,
    output logic               AHB_HWRITE,
    output logic [2:0]         AHB_HSIZE,
    output logic [2:0]         AHB_HBURST,
    output logic [3:0]         AHB_HPROT,
    input  logic [31:0]        AHB_HRDATA,
    input  logic               AHB_HREADY,
    input  logic               AHB_HRESP,
    output logic [511:0]       MSG_BLOCK,
    output logic               BLK_VALID,
    input  logic               BLK_READY,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR
);

    fetch_state_t state, state_nxt;
    logic [12:0]  sar_q, bsr_q, blk_cnt;
    logic [4:0]   addr_cnt, dat_cnt;
    logic         done_q, err_q;
    logic         dph, beat_wr, err_hit, addr_acc, last_blk;
    logic [19:0]  word_addr;

    // A data phase is outstanding whenever more addresses were accepted than beats captured.
    assign dph       = (state == BURST) && (dat_cnt != addr_cnt);
    assign beat_wr   = dph && AHB_HREADY && !AHB_HRESP;
    assign err_hit   = dph && AHB_HRESP && !AHB_HREADY;
    assign addr_acc  = (AHB_HTRANS != HTRANS_IDLE) && AHB_HREADY;
    assign last_blk  = (blk_cnt + 13'd1 == bsr_q);
    assign word_addr = blk_base(sar_q, blk_cnt) | {14'd0, addr_cnt[3:0], 2'b00};

    assign AHB_HADDR  = (state == ADDR || state == BURST) ? HADDR_W'(word_addr) : '0;
    assign AHB_HWRITE = 1'b0;
    assign AHB_HSIZE  = HSIZE_WORD;
    assign AHB_HBURST = HBURST_INCR16;
    assign AHB_HPROT  = HPROT_DATA;
    assign BLK_VALID  = (state == HOLD);
    assign BUSY       = (state != IDLE);
    assign DONE       = done_q;
    assign ERR        = err_q;

    always_ff @(posedge AHB_HCLK or posedge AHB_HRESET) begin
        if (AHB_HRESET) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        AHB_HTRANS = HTRANS_IDLE;
        case (state)
            IDLE:  if (START) state_nxt = (BSR == 13'd0) ? FIN : ADDR;
            ADDR: begin
                AHB_HTRANS = HTRANS_NONSEQ;
                if (AHB_HREADY) state_nxt = BURST;
            end
            BURST: begin
                if (!addr_cnt[4]) AHB_HTRANS = HTRANS_SEQ;
                // First ERROR cycle: cancel the pending address right away.
                if (err_hit) begin
                    AHB_HTRANS = HTRANS_IDLE;
                    state_nxt  = FIN;
                end else if (beat_wr && dat_cnt == 5'd15) begin
                    state_nxt = HOLD;
                end
            end
            HOLD:  if (BLK_READY) state_nxt = last_blk ? FIN : ADDR;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge AHB_HCLK or posedge AHB_HRESET) begin
        if (AHB_HRESET) begin
            sar_q    <= '0;
            bsr_q    <= '0;
            blk_cnt  <= '0;
            addr_cnt <= '0;
            dat_cnt  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= (state == FIN);
            if (state == IDLE && START) begin
                sar_q    <= SAR_ADDR;
                bsr_q    <= BSR;
                blk_cnt  <= '0;
                addr_cnt <= '0;
                dat_cnt  <= '0;
                err_q    <= 1'b0;
            end else begin
                if (addr_acc) addr_cnt <= addr_cnt + 5'd1;
                if (beat_wr)  dat_cnt  <= dat_cnt + 5'd1;
                if (err_hit)  err_q    <= 1'b1;
                if (state == HOLD && BLK_READY) begin
                    blk_cnt  <= blk_cnt + 13'd1;
                    addr_cnt <= '0;
                    dat_cnt  <= '0;
                end
            end
        end
    end

    sm3_blk_buf u_buf (
        .clk    (AHB_HCLK),
        .rst    (AHB_HRESET),
        .clr    (err_hit),
        .wr_en  (beat_wr),
        .wr_idx (dat_cnt[3:0]),
        .wr_dat (AHB_HRDATA),
        .blk    (MSG_BLOCK)
    );

endmodule

// File: tb/tb_sm3_ahb_fetch.sv
// Randomized bench for sm3_ahb_fetch: AHB slave with wait/error injection, block sink, reference scoreboard.
module tb_sm3_ahb_fetch;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start;
    logic [12:0]  sar_addr, bsr;
    logic [31:0]  haddr, hrdata;
    logic [1:0]   htrans;
    logic         hwrite, hready, hresp;
    logic [2:0]   hsize, hburst;
    logic [3:0]   hprot;
    logic [511:0] msg_block;
    logic         blk_valid, blk_ready, busy, done, err;

    always #5 clk = ~clk;

    sm3_ahb_fetch #(.HADDR_W(32)) dut (
        .AHB_HCLK(clk), .AHB_HRESET(rst), .START(start), .SAR_ADDR(sar_addr), .BSR(bsr),
        .AHB_HADDR(haddr), .AHB_HTRANS(htrans), .AHB_HWRITE(hwrite), .AHB_HSIZE(hsize),
        .AHB_HBURST(hburst), .AHB_HPROT(hprot), .AHB_HRDATA(hrdata), .AHB_HREADY(hready),
        .AHB_HRESP(hresp), .MSG_BLOCK(msg_block), .BLK_VALID(blk_valid), .BLK_READY(blk_ready),
        .BUSY(busy), .DONE(done), .ERR(err)
    );

    int checks = 0, failures = 0;
    int job_sar, job_bsr, acc_idx, blk_idx, nonseq_cnt, valid_cycles, err_seen;
    int done_cnt = 0, done_base = 0;
    int ready_delay = 0, wait_beat = -1, wait_n = 0, err_beat = -1;
    bit rand_waits = 0, readdr_pending = 0;
    logic [1:0]   prev_trans;
    logic [31:0]  prev_addr, last_addr;
    logic         prev_rdy;
    logic [511:0] last_msg;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] exp_addr(input int sar, input int b, input int k);
        return 32'((sar + b) * 64 + 4 * k);
    endfunction

    function automatic logic [511:0] exp_block(input int sar, input int b);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[511 - 32*k -: 32] = mem_word(exp_addr(sar, b, k));
        return r;
    endfunction

    function automatic int waits_for(input int beat);
        if (beat == wait_beat) return wait_n;
        if (rand_waits && $urandom_range(0, 3) == 0) return int'($urandom_range(1, 2));
        return 0;
    endfunction

    // AHB slave and block sink: observe mid-cycle, update just after the rising edge.
    initial begin : slave
        bit          dp_vld, dp_err, err_step, o_new, o_done, o_v, o_r;
        logic [31:0] dp_addr, o_addr;
        int          wait_left, hold_cnt;
        dp_vld = 0; dp_err = 0; err_step = 0; dp_addr = 0; wait_left = 0; hold_cnt = 0;
        forever begin
            @(negedge clk);
            o_new  = htrans[1] && hready;
            o_addr = haddr;
            o_done = dp_vld && hready;
            o_v    = blk_valid;
            o_r    = blk_ready;
            @(posedge clk);
            #1;
            if (rst) begin
                dp_vld = 0; hold_cnt = 0;
            end else begin
                if (o_done) dp_vld = 0;
                if (o_new) begin
                    dp_vld    = 1;
                    dp_addr   = o_addr;
                    dp_err    = (int'(o_addr[5:2]) == err_beat);
                    err_step  = 0;
                    wait_left = waits_for(int'(o_addr[5:2]));
                end
                if (o_v && o_r) hold_cnt = 0;
                else if (o_v)   hold_cnt++;
            end
            blk_ready = (hold_cnt >= ready_delay);
            hresp  = 1'b0;
            hready = 1'b1;
            hrdata = 32'hDEAD_BEEF;
            if (dp_vld) begin
                if (dp_err) begin
                    hresp    = 1'b1;
                    hready   = err_step;
                    err_step = 1;
                end else if (wait_left > 0) begin
                    hready = 1'b0;
                    wait_left--;
                end else begin
                    hrdata = mem_word(dp_addr);
                end
            end
        end
    end

    // Scoreboard: every accepted address, held block and handshake against the reference.
    always @(negedge clk) begin
        if (rst) begin
            prev_trans = 2'b00; prev_rdy = 1'b1; readdr_pending = 0;
        end else begin
            if (readdr_pending) begin
                chk("readdr_nonseq", htrans, 2'b10);
                readdr_pending = 0;
            end
            if (prev_trans != 2'b00 && !prev_rdy && !hresp) begin
                chk("stable_htrans", htrans, prev_trans);
                chk("stable_haddr", haddr, prev_addr);
            end
            if (hresp && !hready) begin
                chk("err_htrans_idle", htrans, 2'b00);
                err_seen++;
            end
            if (htrans != 2'b00 && hready) begin
                if (acc_idx < job_bsr * 16) begin
                    chk("haddr", haddr, exp_addr(job_sar, acc_idx / 16, acc_idx % 16));
                    chk("htrans", htrans, (acc_idx % 16 == 0) ? 2'b10 : 2'b11);
                end else begin
                    chk("extra_transfer", acc_idx + 1, job_bsr * 16);
                end
                if (htrans == 2'b10) nonseq_cnt++;
                last_addr = haddr;
                acc_idx++;
            end
            if (blk_valid) begin
                chk("no_addr_in_hold", htrans, 2'b00);
                chk("msg_block", msg_block, exp_block(job_sar, blk_idx));
                valid_cycles++;
                if (blk_ready) begin
                    chk("hold_len", valid_cycles, ready_delay + 1);
                    last_msg = msg_block;
                    blk_idx++;
                    valid_cycles = 0;
                    readdr_pending = (blk_idx < job_bsr);
                end
            end
            if (done) done_cnt++;
            prev_trans = htrans; prev_addr = haddr; prev_rdy = hready;
        end
    end

    task automatic start_job(input logic [12:0] s, input logic [12:0] b);
        @(posedge clk); #1;
        job_sar = int'(s); job_bsr = int'(b);
        acc_idx = 0; blk_idx = 0; nonseq_cnt = 0; valid_cycles = 0; err_seen = 0;
        done_base = done_cnt;
        sar_addr = s; bsr = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sar_addr = 13'($urandom);
        bsr = 13'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_count", done_cnt - done_base, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("busy_after", busy, 1'b0);
    endtask

    task automatic run_job(input logic [12:0] s, input logic [12:0] b, input bit exp_err);
        start_job(s, b);
        @(negedge clk);
        chk("first_nonseq", htrans, 2'b10);
        chk("first_haddr", haddr, exp_addr(int'(s), 0, 0));
        wait_done(4000);
        if (exp_err) begin
            chk("err_flag", err, 1'b1);
            chk("err_blocks", blk_idx, 0);
            chk("err_accepted", acc_idx, err_beat + 1);
            chk("err_cycles", err_seen, 1);
        end else begin
            chk("err_flag", err, 1'b0);
            chk("blocks", blk_idx, b);
            chk("accepted", acc_idx, 16 * b);
            chk("nonseq", nonseq_cnt, b);
            chk("err_cycles", err_seen, 0);
        end
    endtask

    initial begin
        int n;
        start = 0; sar_addr = 0; bsr = 0; hrdata = 0; hready = 1; hresp = 0; blk_ready = 1;
        job_sar = 0; job_bsr = 0; acc_idx = 0; blk_idx = 0; nonseq_cnt = 0; valid_cycles = 0; err_seen = 0;
        @(negedge clk);
        chk("rst_htrans", htrans, 2'b00);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_valid", blk_valid, 1'b0);
        chk("rst_msg", msg_block, 512'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("hwrite", hwrite, 1'b0);
        chk("hsize", hsize, 3'b010);
        chk("hburst", hburst, 3'b111);
        chk("hprot", hprot, 4'b0011);
        @(posedge clk); #1 rst = 1'b0;

        // single block, zero-wait slave
        run_job(13'h0002, 13'd1, 0);
        chk("a_last_haddr", last_addr, 32'h0000_00BC);
        chk("a_word0", last_msg[511:480], mem_word(32'h80));

        // three blocks, sink stalls 10 cycles per block
        ready_delay = 10;
        run_job(13'h0002, 13'd3, 0);
        chk("b_last_haddr", last_addr, 32'h0000_013C);
        ready_delay = 0;

        // wait states: two on beat 7 plus random ones elsewhere
        wait_beat = 7; wait_n = 2; rand_waits = 1;
        run_job(13'($urandom), 13'd2, 0);
        wait_beat = -1; rand_waits = 0;

        // ERROR on beat 5 aborts the job
        err_beat = 5;
        run_job(13'($urandom), 13'd2, 1);
        err_beat = -1;

        // zero-length job
        start_job(13'($urandom), 13'd0);
        @(negedge clk);
        chk("z_busy_c1", busy, 1'b1);
        chk("z_done_c1", done, 1'b0);
        chk("z_err_cleared", err, 1'b0);
        chk("z_htrans_c1", htrans, 2'b00);
        @(negedge clk);
        chk("z_done_c2", done, 1'b1);
        chk("z_busy_c2", busy, 1'b0);
        @(negedge clk);
        chk("z_done_c3", done, 1'b0);
        #1 chk("z_no_transfer", acc_idx, 0);

        // reset while beat 9 is on the bus
        start_job(13'h0100, 13'd1);
        n = 0;
        while (acc_idx < 10 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("f_reached_beat9", acc_idx, 10);
        rst = 1'b1;
        #1;
        chk("f_rst_htrans", htrans, 2'b00);
        chk("f_rst_haddr", haddr, 32'h0);
        chk("f_rst_busy", busy, 1'b0);
        chk("f_rst_valid", blk_valid, 1'b0);
        chk("f_rst_msg", msg_block, 512'h0);
        chk("f_rst_done", done, 1'b0);
        chk("f_rst_err", err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("f_no_done_after_rst", done_cnt, done_base);
        run_job(13'($urandom), 13'd2, 0);

        // carry of the block index into address bit 19
        run_job(13'h1FFF, 13'd2, 0);
        chk("g_carry_addr", last_addr, 32'h0008_003C);

        // random jobs with random waits and sink stalls
        rand_waits = 1;
        for (int j = 0; j < 4; j++) begin
            ready_delay = int'($urandom_range(0, 3));
            run_job(13'($urandom), 13'($urandom_range(1, 3)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm3_ahb_fetch.md
SM3_AHB_FETCH -- requirements
Module: sm3_ahb_fetch

Interface
REQ-001 SHALL have parameter HADDR_W, default 32, AHB address width.
REQ-002 SHALL have the port AHB_HCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have the port AHB_HRESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have the port START, input, 1 bit: one-cycle pulse that begins a fetch job.
REQ-005 SHALL have the port SAR_ADDR, input, 13 bits: source block index, where byte address = {SAR_ADDR+blk, 6'b0}, zero-extended.
REQ-006 SHALL have the port BSR, input, 13 bits: number of 64-byte blocks to fetch.
REQ-007 SHALL have the port AHB_HADDR, output, HADDR_W bits; AHB_HTRANS, output, 2 bits; AHB_HWRITE, output, 1 bit (always 0); AHB_HSIZE, output, 3 bits (always 3'b010); AHB_HBURST, output, 3 bits (always INCR16 3'b111); AHB_HPROT, output, 4 bits (always 4'b0011).
REQ-008 SHALL have the ports AHB_HRDATA, input, 32 bits; AHB_HREADY, input, 1 bit; AHB_HRESP, input, 1 bit (0 OKAY, 1 ERROR).
REQ-009 SHALL have the ports MSG_BLOCK, output, 512 bits; BLK_VALID, output, 1 bit; BLK_READY, input, 1 bit: the block handshake toward the SM3 core.
REQ-010 SHALL have the ports BUSY, output, 1 bit; DONE, output, 1 bit (one-cycle pulse); ERR, output, 1 bit (sticky until the next START).

Function
REQ-011 SHALL implement states IDLE, ADDR, BURST, HOLD and FIN.
REQ-012 IDLE: on START with BSR≠0, SHALL latch SAR_ADDR/BSR, clear ERR, and go to ADDR; with BSR=0, SHALL go to FIN and issue no transfer.
REQ-013 ADDR: SHALL drive HTRANS=NONSEQ and HADDR=block base; when HREADY=1, SHALL go to BURST. The first NONSEQ SHALL appear the cycle after START.
REQ-014 BURST: SHALL drive SEQ beats 1..15, with HADDR incrementing by 4 on each HREADY=1. After beat 15's address is accepted, HTRANS SHALL be IDLE.
REQ-015 SHALL hold address/control stable while HREADY=0.
REQ-016 SHALL capture a data beat only in the cycle where HREADY=1 and the data phase is active. Beat k SHALL be stored in MSG_BLOCK[511-32k -: 32] (word 0 most significant).
REQ-017 After the 16th data beat, SHALL go to HOLD with BLK_VALID=1 and MSG_BLOCK stable.
REQ-018 HOLD: when BLK_VALID&BLK_READY, SHALL increment the block counter. If more blocks remain, SHALL go to ADDR next cycle; otherwise SHALL go to FIN.
REQ-019 FIN: SHALL pulse DONE for one cycle, then go to IDLE.
REQ-020 BUSY SHALL be 1 in every state except IDLE.
REQ-021 On HRESP=1 with HREADY=0 (first ERROR cycle), SHALL drive HTRANS=IDLE in that same cycle, set ERR, discard the partial block, and go to FIN. BLK_VALID SHALL never assert for the aborted block.
REQ-022 SHALL ignore START while BUSY=1.
REQ-023 Block address arithmetic SHALL be 13-bit plus counter, carried into bit 19 (no wrap). Bursts SHALL never cross a 1 KB boundary, because each is 64-byte aligned.

Reset
REQ-024 AHB_HRESET SHALL force state IDLE asynchronously: HTRANS=IDLE, HADDR=0, BLK_VALID=0, MSG_BLOCK=0, BUSY=0, DONE=0, ERR=0, counters=0.
REQ-025 Reset mid-burst SHALL abandon the transfer with no DONE pulse.

Structure
REQ-026 SHALL take from shared package sm3_ahb_pkg: the HTRANS/HBURST/HSIZE encodings, the state enum, and BLOCK_WORDS=16.
REQ-027 SHALL place the 16x32 word assembly register in sub-module sm3_blk_buf; the control FSM and counters SHALL be in sm3_ahb_fetch.

Verification
REQ-028 SAR_ADDR=13'h0002, BSR=1, zero-wait slave -> HADDR 0x80..0xBC, 1 NONSEQ+15 SEQ, BLK_VALID with word0=mem[0x80] in MSG_BLOCK[511:480], then DONE.
REQ-029 BSR=3, BLK_READY held low 10 cycles per block -> no new NONSEQ until handshake; 3 blocks from 0x80,0xC0,0x100; one DONE.
REQ-030 Random HREADY=0 insertion (2 waits on beat 7) -> HADDR/HTRANS stable during waits; data identical to zero-wait case.
REQ-031 ERROR response on beat 5 -> HTRANS=IDLE in first ERROR cycle, ERR=1, no BLK_VALID, DONE pulse, BUSY=0 after.
REQ-032 BSR=0 START -> no HTRANS≠IDLE, DONE two cycles after START.
REQ-033 AHB_HRESET asserted during beat 9 -> outputs at reset values immediately; a fresh START afterward completes normally.
